// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants, RV32M funct3 codes, FSM state encoding and
//               operand-signedness helpers for the iterative mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int XLEN = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as two's complement for MULH, DIV and REM
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Request / register-file write bundle between the core control
//               and the mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            illegal;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            rd_wen;

  // Core side: issues requests, consumes the write request
  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, illegal, rd_addr, rd_data, rd_wen
  );

  // Unit side
  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, illegal, rd_addr, rd_data, rd_wen
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sign_fix
// Description : Combinational conditional two's-complement negate. Used both
//               to take operand magnitudes and to restore the result sign.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  wire logic         i_neg,
  input  wire logic [W-1:0] i_val,
  output logic      [W-1:0] o_val
);

  // Negating a value with its sign bit set yields its magnitude, so the same
  // block serves as abs() when i_neg is driven by the operand sign.
  assign o_val = i_neg ? ((~i_val) + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//               restoring divide, one bit per cycle, operating on operand
//               magnitudes with a final sign fix. Result is presented as a
//               one-cycle register-file write request.
//               Build option MULDIV_DIV_EN: when defined the divider is built
//               and all eight ops are supported; otherwise DIV/DIVU/REM/REMU
//               raise a one-cycle illegal pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst_n,
  muldiv_if.slave   io
);

  state_t            r_state;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_sign;
  logic [XLEN-1:0]   r_hi;      // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;      // multiplier shifting out / quotient shifting in
  logic [XLEN-1:0]   r_b;       // multiplicand or divisor magnitude
  logic [5:0]        r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_illegal;
  logic              r_wen;
  logic [XLEN-1:0]   r_data;

  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_res_sign;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_fix_in;
  logic [2*XLEN-1:0] w_fix_out;
  logic [XLEN-1:0]   w_result;

  // Operand magnitudes, only for the positions the op treats as signed
  assign w_a_neg = io.op_a[XLEN-1] && a_is_signed(io.funct3);
  assign w_b_neg = io.op_b[XLEN-1] && b_is_signed(io.funct3);

  // Remainder follows the dividend; product and quotient follow a XOR b
  assign w_res_sign = (io.funct3 == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (
    .i_neg (w_a_neg),
    .i_val (io.op_a),
    .o_val (w_abs_a)
  );

  muldiv_sign_fix #(.W(XLEN)) u_abs_b (
    .i_neg (w_b_neg),
    .i_val (io.op_b),
    .o_val (w_abs_b)
  );

  // One shift-add step: add multiplicand into the high half, then shift the
  // whole {carry, hi, lo} right so the multiplier's next bit reaches lo[0].
  assign w_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {XLEN{1'b0}})};

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic              w_div0;
  logic              w_ovf;

  // Restoring step: bring in the next dividend bit; the difference is always
  // below the divisor when kept, so 32 bits of the subtraction suffice.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_sub   = w_shift[XLEN-1:0] - r_b;

  assign w_div0  = (io.op_b == {XLEN{1'b0}});
  assign w_ovf   = ((io.funct3 == F3_DIV) || (io.funct3 == F3_REM)) &&
                   (io.op_a == 32'h8000_0000) && (io.op_b == 32'hFFFF_FFFF);
`endif

  // Pick which raw magnitude the final sign fix operates on
  always_comb begin
    w_fix_in = {r_hi, r_lo};
`ifdef MULDIV_DIV_EN
    case (r_f3)
      F3_DIV, F3_DIVU: w_fix_in = {{XLEN{1'b0}}, r_lo};
      F3_REM, F3_REMU: w_fix_in = {{XLEN{1'b0}}, r_hi};
      default:         w_fix_in = {r_hi, r_lo};
    endcase
`endif
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_res_fix (
    .i_neg (r_sign),
    .i_val (w_fix_in),
    .o_val (w_fix_out)
  );

  // MULH* return the upper word; MUL and all divide ops the lower word
  always_comb begin
    w_result = w_fix_out[XLEN-1:0];
    if ((r_f3 == F3_MULH) || (r_f3 == F3_MULHSU) || (r_f3 == F3_MULHU))
      w_result = w_fix_out[2*XLEN-1:XLEN];
  end

  // Control FSM with iteration counter, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_f3      <= F3_MUL;
      r_rd      <= 5'd0;
      r_sign    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_cnt     <= 6'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_wen     <= 1'b0;
      r_data    <= '0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io.start) begin
            if (io.funct3[2]) begin
`ifdef MULDIV_DIV_EN
              r_f3   <= io.funct3;
              r_rd   <= io.rd_in;
              r_busy <= 1'b1;
              r_cnt  <= 6'd0;
              if (w_div0) begin
                // Quotient all ones; remainder is the dividend itself
                r_hi    <= w_abs_a;
                r_lo    <= {XLEN{1'b1}};
                r_sign  <= (io.funct3 == F3_REM) && w_a_neg;
                r_state <= S_FIX;
              end else if (w_ovf) begin
                r_hi    <= '0;
                r_lo    <= 32'h8000_0000;
                r_sign  <= 1'b0;
                r_state <= S_FIX;
              end else begin
                r_hi    <= '0;
                r_lo    <= w_abs_a;
                r_b     <= w_abs_b;
                r_sign  <= w_res_sign;
                r_state <= S_CALC;
              end
`else
              r_illegal <= 1'b1;
`endif
            end else begin
              r_f3    <= io.funct3;
              r_rd    <= io.rd_in;
              r_busy  <= 1'b1;
              r_cnt   <= 6'd0;
              r_hi    <= '0;
              r_lo    <= w_abs_b;
              r_b     <= w_abs_a;
              r_sign  <= w_res_sign;
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31)
            r_state <= S_FIX;
`ifdef MULDIV_DIV_EN
          if (r_f3[2]) begin
            r_hi <= w_ge ? w_sub : w_shift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_ge};
          end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end
`else
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
`endif
        end

        S_FIX: begin
          r_data  <= w_result;
          r_done  <= 1'b1;
          r_wen   <= (r_rd != 5'd0);
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_wen   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.busy    = r_busy;
  assign io.done    = r_done;
  assign io.illegal = r_illegal;
  assign io.rd_addr = r_rd;
  assign io.rd_data = r_data;
  assign io.rd_wen  = r_wen;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Directed cases plus
//               randomized ops compared against an arithmetic RV32M model.
//               Adapts to the MULDIV_DIV_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit op_supported(input logic [2:0] f3);
`ifdef MULDIV_DIV_EN
    return 1'b1;
`else
    return !f3[2];
`endif
  endfunction

  // Reference RV32M semantics using plain integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    u  = {32'd0, a} * {32'd0, b};
    case (f3)
      F3_MUL:    return u[31:0];
      F3_MULH: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p[63:32];
      end
      F3_MULHSU: begin
        p = longint'($signed(a)) * longint'({32'd0, b});
        return p[63:32];
      end
      F3_MULHU:  return u[63:32];
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      F3_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default:   return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && (b == 32'd0)) return 2;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and check its complete response; poke_at>0 re-asserts start
  // in that cycle of the busy window to confirm it is ignored.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int poke_at, input string tag);
    int lat;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    @(negedge clk);
    lat        = 1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
    bus.rd_in  = 5'($urandom);
    if (!op_supported(f3)) begin
      check({tag, ".illegal"}, 64'(bus.illegal), 64'd1);
      check({tag, ".illegal_busy"}, 64'(bus.busy), 64'd0);
      @(negedge clk);
      check({tag, ".illegal_clr"}, 64'(bus.illegal), 64'd0);
      check({tag, ".illegal_nodone"}, 64'({bus.done, bus.rd_wen, bus.busy}), 64'd0);
      return;
    end
    check({tag, ".busy"}, 64'(bus.busy), 64'd1);
    while (!bus.done && lat < 60) begin
      if (lat == poke_at) begin
        bus.start  = 1'b1;
        bus.funct3 = 3'($urandom);
        bus.rd_in  = 5'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, ".done"}, 64'(bus.done), 64'd1);
    check({tag, ".latency"}, 64'(lat), 64'(ref_latency(f3, a, b)));
    check({tag, ".rd_data"}, 64'(bus.rd_data), 64'(ref_result(f3, a, b)));
    check({tag, ".rd_addr"}, 64'(bus.rd_addr), 64'(rd));
    check({tag, ".rd_wen"}, 64'(bus.rd_wen), 64'(rd != 5'd0));
    check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    check({tag, ".after_done"}, 64'({bus.done, bus.rd_wen, bus.busy}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          nd;
    logic [2:0]  rf3;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.funct3 = 3'd0;
    bus.op_a   = 32'd0;
    bus.op_b   = 32'd0;
    bus.rd_in  = 5'd0;
    repeat (3) @(negedge clk);
    check("reset.busy",    64'(bus.busy),    64'd0);
    check("reset.done",    64'(bus.done),    64'd0);
    check("reset.illegal", 64'(bus.illegal), 64'd0);
    check("reset.rd_wen",  64'(bus.rd_wen),  64'd0);
    check("reset.rd_addr", 64'(bus.rd_addr), 64'd0);
    check("reset.rd_data", 64'(bus.rd_data), 64'd0);
    rst_n = 1'b1;

    // Directed cases
    run_op(F3_MUL,    32'd7,         32'd6,         5'd5,  0, "mul_7x6");
    run_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  0, "mulh_m1");
    run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  0, "mulhu_max");
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  0, "mulhsu_m1");
    run_op(F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd4,  0, "div_m7_2");
    run_op(F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd6,  0, "rem_m7_2");
    run_op(F3_DIVU,   32'd5,         32'd0,         5'd7,  0, "divu_by0");
    run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  0, "rem_ovf");
    run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  0, "div_ovf");
    run_op(F3_REM,    32'hFFFF_FFF0, 32'd0,         5'd10, 0, "rem_by0");

    // Write to x0 suppressed; a start during busy is dropped
    run_op(F3_MUL, 32'd123, 32'd456, 5'd0, 10, "mul_x0_poke");
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("poke.no_second_done", 64'(nd), 64'd0);

    // Reset in the middle of an iterating op
    rf3 = op_supported(F3_DIV) ? F3_DIV : F3_MULHU;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = rf3;
    bus.op_a   = $urandom | 32'd1;
    bus.op_b   = 32'd3;
    bus.rd_in  = 5'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset.busy",    64'(bus.busy),    64'd0);
    check("midreset.done",    64'(bus.done),    64'd0);
    check("midreset.illegal", 64'(bus.illegal), 64'd0);
    check("midreset.rd_wen",  64'(bus.rd_wen),  64'd0);
    check("midreset.rd_addr", 64'(bus.rd_addr), 64'd0);
    check("midreset.rd_data", 64'(bus.rd_data), 64'd0);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.rd_wen) nd++;
    end
    check("midreset.no_write", 64'(nd), 64'd0);
    run_op(F3_DIVU, 32'd100, 32'd7, 5'd12, 0, "after_reset");

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             5'($urandom_range(0, 31)), 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
